// File: rtl/writeback_unit.sv
// Final pipeline stage: registered register-file write port, LR/SC reservation, SC result and sticky halt.
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module writeback_unit #(
    parameter int RESV_GRAN = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        m_valid,
    input  logic        m_stall,
    input  logic        m_reg_write,
    input  logic [2:0]  m_final_mux,
    input  logic [4:0]  m_rd,
    input  logic [31:0] m_alu_out,
    input  logic [31:0] m_dmemload,
    input  logic [31:0] m_pc_plus4,
    input  logic [31:0] m_u_type,
    input  logic        m_mem_read,
    input  logic        m_mem_write,
    input  logic        m_atomic,
    input  logic        m_halt,
    input  logic        snoop_inv,
    input  logic [31:0] snoop_addr,
    output logic        sc_pass,
    output logic        WEN,
    output logic [4:0]  wsel,
    output logic [31:0] wdat,
    output logic        halt,
    output logic        resv_valid,
    output logic [31:0] resv_addr
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    logic        accept;
    logic [31:0] wb_data;
    logic        resv_valid_next;
    logic [31:0] resv_addr_next;

    // Word-granular compare: low RESV_GRAN bits are ignored.
    function automatic logic addr_match(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) >> RESV_GRAN) == 32'd0;
    endfunction

    assign accept  = m_valid & ~m_stall & ~halt;
    assign sc_pass = m_valid & m_mem_write & m_atomic & resv_valid
                   & addr_match(m_alu_out, resv_addr);

    always_comb begin
        wb_data = m_alu_out;
        case (m_final_mux)
            3'd1:    wb_data = m_dmemload;
            3'd2:    wb_data = m_pc_plus4;
            3'd3:    wb_data = m_u_type;
            3'd4:    wb_data = {31'd0, ~sc_pass};
            default: wb_data = m_alu_out;
        endcase
    end

    // Snoop is checked against the post-update address so it also kills a same-cycle LR.
    always_comb begin
        resv_valid_next = resv_valid;
        resv_addr_next  = resv_addr;
        if (accept) begin
            if (m_mem_write & m_atomic) begin
                resv_valid_next = 1'b0;
            end else if (m_mem_read & m_atomic) begin
                resv_valid_next = 1'b1;
                resv_addr_next  = m_alu_out;
            end else if (m_mem_write & addr_match(m_alu_out, resv_addr)) begin
                resv_valid_next = 1'b0;
            end
        end
        if (snoop_inv & addr_match(snoop_addr, resv_addr_next)) begin
            resv_valid_next = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            WEN        <= 1'b0;
            wsel       <= 5'd0;
            wdat       <= 32'd0;
            halt       <= 1'b0;
            resv_valid <= 1'b0;
            resv_addr  <= 32'd0;
        end else begin
            WEN        <= accept & m_reg_write & (m_rd != 5'd0);
            resv_valid <= resv_valid_next;
            resv_addr  <= resv_addr_next;
            if (accept) begin
                wsel <= m_rd;
                wdat <= wb_data;
                if (m_halt) begin
                    halt <= 1'b1;
                end
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Counts every accepted instruction, halt included; accept is already false once halted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            retire_cnt <= 32'd0;
        end else if (accept) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: driver queues expected writes, negedge monitor checks them.
// Retire counter checks are compiled in when WB_RETIRE_CNT_EN is defined.
module tb_writeback_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        m_valid, m_stall, m_reg_write;
    logic [2:0]  m_final_mux;
    logic [4:0]  m_rd;
    logic [31:0] m_alu_out, m_dmemload, m_pc_plus4, m_u_type;
    logic        m_mem_read, m_mem_write, m_atomic, m_halt;
    logic        snoop_inv;
    logic [31:0] snoop_addr;
    logic        sc_pass, WEN, halt, resv_valid;
    logic [4:0]  wsel;
    logic [31:0] wdat, resv_addr;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    typedef struct {
        logic [4:0]  wsel;
        logic [31:0] wdat;
    } wb_exp_t;

    wb_exp_t     exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        exp_halt = 1'b0;
    logic [31:0] exp_retire = 32'd0;

    writeback_unit #(.RESV_GRAN(2)) dut (
        .CLK(CLK), .RST(RST),
        .m_valid(m_valid), .m_stall(m_stall), .m_reg_write(m_reg_write),
        .m_final_mux(m_final_mux), .m_rd(m_rd), .m_alu_out(m_alu_out),
        .m_dmemload(m_dmemload), .m_pc_plus4(m_pc_plus4), .m_u_type(m_u_type),
        .m_mem_read(m_mem_read), .m_mem_write(m_mem_write), .m_atomic(m_atomic),
        .m_halt(m_halt), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .sc_pass(sc_pass), .WEN(WEN), .wsel(wsel), .wdat(wdat), .halt(halt),
        .resv_valid(resv_valid), .resv_addr(resv_addr)
`ifdef WB_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic clearInputs();
        m_valid = 0; m_stall = 0; m_reg_write = 0; m_final_mux = 3'd0; m_rd = 5'd0;
        m_alu_out = 32'd0; m_dmemload = 32'd0; m_pc_plus4 = 32'd0; m_u_type = 32'd0;
        m_mem_read = 0; m_mem_write = 0; m_atomic = 0; m_halt = 0;
        snoop_inv = 0; snoop_addr = 32'd0;
    endtask

    // Queue the expected write, advance one cycle, then check WEN and halt.
    task automatic applyStimulus(input logic exp_wen, input logic [4:0] exp_wsel, input logic [31:0] exp_wdat);
        wb_exp_t e;
        if (exp_wen) begin
            e.wsel = exp_wsel;
            e.wdat = exp_wdat;
            exp_q.push_back(e);
        end
        if (RST) begin
            exp_retire = 32'd0;
            exp_halt   = 1'b0;
        end else if (m_valid && !m_stall && !exp_halt) begin
            exp_retire = exp_retire + 32'd1;
            if (m_halt) exp_halt = 1'b1;
        end
        @(posedge CLK);
        #1;
        checkOutput("wen", {31'd0, WEN}, {31'd0, exp_wen});
        checkOutput("halt", {31'd0, halt}, {31'd0, exp_halt});
        clearInputs();
    endtask

    task automatic setWrite(input logic [4:0] rd, input logic [2:0] fmux, input logic [31:0] alu);
        m_valid = 1; m_reg_write = 1; m_rd = rd; m_final_mux = fmux; m_alu_out = alu;
    endtask

    task automatic setAtomic(input logic is_sc, input logic [31:0] addr);
        m_valid = 1; m_atomic = 1; m_alu_out = addr;
        m_mem_read = ~is_sc; m_mem_write = is_sc;
    endtask

    // Monitor: every asserted WEN must match the oldest queued write.
    always @(negedge CLK) begin
        if (WEN === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_write: got wsel=%0d wdat=0x%08h, expected no write", wsel, wdat);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                checkOutput("wb_wsel", {27'd0, wsel}, {27'd0, e.wsel});
                checkOutput("wb_wdat", wdat, e.wdat);
            end
        end
    end

    initial begin
        clearInputs();
        RST = 1;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        RST = 0;
        checkOutput("rst_wsel", {27'd0, wsel}, 32'd0);
        checkOutput("rst_wdat", wdat, 32'd0);
        checkOutput("rst_resv_valid", {31'd0, resv_valid}, 32'd0);
        checkOutput("rst_resv_addr", resv_addr, 32'd0);

        // Source mux coverage
        setWrite(5, 3'd0, 32'h1234);                       applyStimulus(1, 5, 32'h1234);
        applyStimulus(0, 0, 0);
        setWrite(7, 3'd1, 32'h0); m_dmemload = 32'hDEADBEEF; applyStimulus(1, 7, 32'hDEADBEEF);
        setWrite(1, 3'd2, 32'h0); m_pc_plus4 = 32'h44;       applyStimulus(1, 1, 32'h44);
        setWrite(31, 3'd3, 32'h0); m_u_type = 32'hABCD0000;  applyStimulus(1, 31, 32'hABCD0000);
        setWrite(2, 3'd6, 32'h55);                         applyStimulus(1, 2, 32'h55);

        // x0 suppression, no reg_write, and stall hold
        setWrite(0, 3'd0, 32'h99);                         applyStimulus(0, 0, 0);
        checkOutput("x0_wdat", wdat, 32'h99);
        setWrite(4, 3'd0, 32'h42); m_reg_write = 0;         applyStimulus(0, 0, 0);
        setWrite(9, 3'd0, 32'h77); m_stall = 1;             applyStimulus(0, 0, 0);
        checkOutput("stall_wdat", wdat, 32'h42);
        checkOutput("stall_wsel", {27'd0, wsel}, 32'd4);

        // LR/SC success
        setAtomic(0, 32'h100); m_reg_write = 1; m_rd = 10; m_final_mux = 3'd1; m_dmemload = 32'h5;
        applyStimulus(1, 10, 32'h5);
        checkOutput("lr_resv_valid", {31'd0, resv_valid}, 32'd1);
        checkOutput("lr_resv_addr", resv_addr, 32'h100);
        setAtomic(1, 32'h100); m_reg_write = 1; m_rd = 11; m_final_mux = 3'd4;
        #1 checkOutput("sc_ok_pass", {31'd0, sc_pass}, 32'd1);
        applyStimulus(1, 11, 32'd0);
        checkOutput("sc_ok_resv_valid", {31'd0, resv_valid}, 32'd0);

        // SC fail after snoop; non-matching snoop leaves reservation
        setAtomic(0, 32'h200);                             applyStimulus(0, 0, 0);
        snoop_inv = 1; snoop_addr = 32'h400;               applyStimulus(0, 0, 0);
        checkOutput("snoop_miss_valid", {31'd0, resv_valid}, 32'd1);
        snoop_inv = 1; snoop_addr = 32'h202;               applyStimulus(0, 0, 0);
        checkOutput("snoop_hit_valid", {31'd0, resv_valid}, 32'd0);
        setAtomic(1, 32'h200); m_reg_write = 1; m_rd = 12; m_final_mux = 3'd4;
        #1 checkOutput("sc_snoop_pass", {31'd0, sc_pass}, 32'd0);
        applyStimulus(1, 12, 32'd1);

        // Granularity: other word fails, same word passes
        setAtomic(0, 32'h100);                             applyStimulus(0, 0, 0);
        setAtomic(1, 32'h104); m_reg_write = 1; m_rd = 13; m_final_mux = 3'd4;
        #1 checkOutput("sc_gran_pass", {31'd0, sc_pass}, 32'd0);
        applyStimulus(1, 13, 32'd1);
        checkOutput("sc_fail_clears", {31'd0, resv_valid}, 32'd0);
        setAtomic(0, 32'h100);                             applyStimulus(0, 0, 0);
        setAtomic(1, 32'h103); m_reg_write = 1; m_rd = 14; m_final_mux = 3'd4;
        #1 checkOutput("sc_sameword_pass", {31'd0, sc_pass}, 32'd1);
        applyStimulus(1, 14, 32'd0);

        // Plain stores: other word keeps, matching word clears
        setAtomic(0, 32'h100);                             applyStimulus(0, 0, 0);
        m_valid = 1; m_mem_write = 1; m_alu_out = 32'h108; applyStimulus(0, 0, 0);
        checkOutput("st_miss_valid", {31'd0, resv_valid}, 32'd1);
        m_valid = 1; m_mem_write = 1; m_alu_out = 32'h100; applyStimulus(0, 0, 0);
        checkOutput("st_hit_valid", {31'd0, resv_valid}, 32'd0);

        // Snoop overrides same-cycle LR; snoop with SC uses pre-edge state
        setAtomic(0, 32'h500); snoop_inv = 1; snoop_addr = 32'h500; applyStimulus(0, 0, 0);
        checkOutput("lr_snoop_valid", {31'd0, resv_valid}, 32'd0);
        setAtomic(0, 32'h600);                             applyStimulus(0, 0, 0);
        setAtomic(1, 32'h600); m_reg_write = 1; m_rd = 15; m_final_mux = 3'd4;
        snoop_inv = 1; snoop_addr = 32'h600;
        #1 checkOutput("sc_with_snoop_pass", {31'd0, sc_pass}, 32'd1);
        applyStimulus(1, 15, 32'd0);

        // Halt writes back, then blocks further accepts
        setWrite(3, 3'd0, 32'h33); m_halt = 1;             applyStimulus(1, 3, 32'h33);
        setWrite(4, 3'd0, 32'h44);                         applyStimulus(0, 0, 0);
        setAtomic(0, 32'h700);                             applyStimulus(0, 0, 0);
        checkOutput("halt_no_lr", {31'd0, resv_valid}, 32'd0);
        checkOutput("halt_wdat_hold", wdat, 32'h33);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("retire_frozen", retire_cnt, exp_retire);
`endif

        // Reset during a valid write drops it and clears state
        RST = 1; setWrite(8, 3'd0, 32'h88);                applyStimulus(0, 0, 0);
        RST = 0;
        checkOutput("rst2_wdat", wdat, 32'd0);
        checkOutput("rst2_resv_addr", resv_addr, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("rst2_retire", retire_cnt, 32'd0);
`endif
        setWrite(6, 3'd0, 32'h66);                         applyStimulus(1, 6, 32'h66);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("retire_after_rst", retire_cnt, exp_retire);
`endif
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage. Consumes the memory-stage result and produces the register-file write port (WEN, wsel, wdat) that feeds the decode stage's register file.
- Owns the per-core LR/SC reservation register. Invalidates it on coherence snoops and local stores.
- Generates the SC pass/fail result and latches halt.
- Write port is registered: one cycle from memory-stage accept to register-file write.

Parameters:
- RESV_GRAN, 2, number of low address bits ignored for reservation match (word granularity).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- m_valid  in  1  memory-stage instruction valid this cycle
- m_stall  in  1  hold; no new instruction accepted, outputs hold
- m_reg_write  in  1  instruction writes rd
- m_final_mux  in  3  writeback source select
- m_rd  in  5  destination register
- m_alu_out  in  32  ALU result; also memory address for loads/stores/atomics
- m_dmemload  in  32  load data
- m_pc_plus4  in  32  link value
- m_u_type  in  32  LUI/AUIPC value
- m_mem_read  in  1  load (LR when m_atomic=1)
- m_mem_write  in  1  store (SC when m_atomic=1)
- m_atomic  in  1  LR/SC qualifier
- m_halt  in  1  halt instruction
- snoop_inv  in  1  coherence invalidate from the other core
- snoop_addr  in  32  invalidated address
- sc_pass  out  1  combinational: current SC may write memory
- WEN  out  1  register-file write enable (registered)
- wsel  out  5  register-file write select (registered)
- wdat  out  32  register-file write data (registered)
- halt  out  1  sticky halt
- resv_valid  out  1  reservation held
- resv_addr  out  32  reserved address

Behaviour:
- Reset: WEN=0, wsel=0, wdat=0, halt=0, resv_valid=0, resv_addr=0. Reset mid-operation drops any pending write and the reservation.
- Accept condition: m_valid & !m_stall & !halt.
- On accept:
  - WEN <= m_reg_write & (m_rd != 0).
  - wsel <= m_rd.
  - wdat <= mux(m_final_mux).
- Otherwise: WEN <= 0; wsel and wdat hold.
- m_final_mux encoding:
  - 0: ALU
  - 1: dmemload
  - 2: pc_plus4
  - 3: u_type
  - 4: SC result, 32'd0 if sc_pass, else 32'd1
  - 5–7: ALU
- Address match: addr[31:RESV_GRAN] == resv_addr[31:RESV_GRAN].
- sc_pass = m_valid & m_mem_write & m_atomic & resv_valid & addr match against m_alu_out. The memory stage uses it to gate dmemWEN.
- Reservation updates, applied on accept, in this priority:
  1. RST clears.
  2. SC (pass or fail): resv_valid <= 0.
  3. LR: resv_valid <= 1, resv_addr <= m_alu_out.
  4. Plain local store to a matching address: resv_valid <= 0.
- snoop_inv with a matching snoop_addr clears resv_valid in the same cycle regardless of accept. It also overrides a simultaneous LR to the same address: the result is resv_valid=0.
- snoop_inv and SC in the same cycle: sc_pass is evaluated from the pre-edge state. The snoop only affects state after the edge.
- halt: set on an accepted m_halt; sticky until RST. The halt instruction itself writes back normally if m_reg_write. After halt, no accepts occur and WEN=0.
- x0: writes never assert WEN.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- With it: adds output retire_cnt (32 bits).
  - Increments on each accept, including the halt instruction.
  - Frozen after halt; reset to 0; wraps 0xFFFFFFFF -> 0.
- Without it: port and counter absent. All other behaviour is identical.

Test Plan:
- ALU write: m_rd=5, m_final_mux=0, m_alu_out=0x1234, m_reg_write=1 -> next cycle WEN=1, wsel=5, wdat=0x1234; following idle cycle WEN=0.
- x0 suppression and stall:
  - m_rd=0, m_reg_write=1 -> WEN=0.
  - m_stall=1 with valid input -> WEN=0 and wdat unchanged.
- LR/SC success: LR addr 0x100 -> resv_valid=1, resv_addr=0x100. Then SC to 0x100 -> sc_pass=1, wdat=0, resv_valid=0.
- SC fail by snoop: LR 0x200, then snoop_inv at 0x200 -> resv_valid=0. SC to 0x200 -> sc_pass=0, wdat=1.
- Match granularity and store invalidation:
  - SC to 0x104 after LR 0x100 -> sc_pass=0.
  - Plain store to 0x100 after LR 0x100 -> resv_valid=0.
- Halt: m_halt with m_reg_write=1, m_rd=3 -> write occurs and halt=1. Subsequent valid inputs produce WEN=0. RST -> halt=0. With WB_RETIRE_CNT_EN, retire_cnt stays frozen while halted.
